// File: rtl/mb_wb_fetch_bridge_if.sv
// Bus bundle for mb_wb_fetch_bridge: memory-bus request side plus Wishbone master side.
// master = bridge view, slave = requester/Wishbone environment view.
interface mb_wb_fetch_bridge_if #(
    parameter int RW     = 16,
    parameter int ADDR_W = 24
);
    logic [RW-1:0]        mb_req_addr;
    logic                 mb_req_active;
    logic                 mb_req_next;
    logic [ADDR_W-RW-1:0] i_addr_hi;
    logic [RW-1:0]        mb_req_data;
    logic                 mb_req_data_valid;
    logic                 o_bus_err;
    logic                 wb_cyc;
    logic                 wb_stb;
    logic                 wb_we;
    logic [1:0]           wb_sel;
    logic [ADDR_W-1:0]    wb_adr;
    logic [RW-1:0]        wb_i_dat;
    logic                 wb_ack;
    logic                 wb_err;
    logic                 wb_stall;

    modport master (
        input  mb_req_addr, mb_req_active, mb_req_next, i_addr_hi,
        output mb_req_data, mb_req_data_valid, o_bus_err,
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr,
        input  wb_i_dat, wb_ack, wb_err, wb_stall
    );

    modport slave (
        output mb_req_addr, mb_req_active, mb_req_next, i_addr_hi,
        input  mb_req_data, mb_req_data_valid, o_bus_err,
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr,
        output wb_i_dat, wb_ack, wb_err, wb_stall
    );
endinterface

// File: rtl/mb_wb_fetch_bridge.sv
// Read-only 16-bit memory-bus to Wishbone pipelined bridge, one outstanding request,
// cyc locked across "next" pairs. Define MB_WB_TIMEOUT_EN to enable the ack timeout.
module mb_wb_fetch_bridge #(
    parameter int RW             = 16,
    parameter int ADDR_W         = 24,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mb_wb_fetch_bridge_if.master  bus
);
    typedef enum logic [2:0] {IDLE, STB, WAIT, RESP, LOCKED} state_t;

    state_t            state, state_n;
    logic              lock, lock_n;
    logic              cyc, cyc_n;
    logic              stb, stb_n;
    logic [ADDR_W-1:0] adr, adr_n;
    logic [RW-1:0]     data, data_n;
    logic              valid, valid_n;
    logic              berr, berr_n;
    logic              issue;
    logic              done;
    logic [RW-1:0]     rdata;

`ifdef MB_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt, cnt_n;
`endif

    assign done  = bus.wb_ack | bus.wb_err;
    // err wins over a simultaneous ack and returns zero data
    assign rdata = bus.wb_err ? '0 : bus.wb_i_dat;

    always_comb begin
        state_n = state;
        lock_n  = lock;
        cyc_n   = cyc;
        stb_n   = stb;
        adr_n   = adr;
        data_n  = data;
        valid_n = 1'b0;
        berr_n  = 1'b0;
        issue   = 1'b0;
        case (state)
            IDLE: issue = bus.mb_req_active;
            STB: begin
                if (!bus.wb_stall) begin
                    stb_n   = 1'b0;
                    state_n = WAIT;
                    if (done) begin
                        state_n = RESP;
                        data_n  = rdata;
                        valid_n = 1'b1;
                        berr_n  = bus.wb_err;
                    end
                end
            end
            WAIT: begin
                if (done) begin
                    state_n = RESP;
                    data_n  = rdata;
                    valid_n = 1'b1;
                    berr_n  = bus.wb_err;
                end
            end
            RESP: begin
                // requester turnaround: active is not looked at here
                if (lock) begin
                    state_n = LOCKED;
                end else begin
                    state_n = IDLE;
                    cyc_n   = 1'b0;
                end
            end
            LOCKED: begin
                if (bus.mb_req_active) begin
                    issue = 1'b1;
                end else begin
                    state_n = IDLE;
                    cyc_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                cyc_n   = 1'b0;
                stb_n   = 1'b0;
            end
        endcase
        if (issue) begin
            state_n = STB;
            cyc_n   = 1'b1;
            stb_n   = 1'b1;
            adr_n   = {bus.i_addr_hi, bus.mb_req_addr};
            lock_n  = bus.mb_req_next;
        end
`ifdef MB_WB_TIMEOUT_EN
        cnt_n = cnt;
        if (issue) begin
            cnt_n = '0;
        end else if (state == STB || state == WAIT) begin
            if (cnt == CNT_W'(TIMEOUT_CYCLES) && state_n != RESP) begin
                state_n = IDLE;
                cyc_n   = 1'b0;
                stb_n   = 1'b0;
                lock_n  = 1'b0;
                data_n  = {RW{1'b1}};
                valid_n = 1'b1;
                berr_n  = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            lock  <= 1'b0;
            cyc   <= 1'b0;
            stb   <= 1'b0;
            adr   <= '0;
            data  <= '0;
            valid <= 1'b0;
            berr  <= 1'b0;
        end else begin
            state <= state_n;
            lock  <= lock_n;
            cyc   <= cyc_n;
            stb   <= stb_n;
            adr   <= adr_n;
            data  <= data_n;
            valid <= valid_n;
            berr  <= berr_n;
        end
    end

`ifdef MB_WB_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) cnt <= '0;
        else       cnt <= cnt_n;
    end
`endif

    assign bus.wb_cyc            = cyc;
    assign bus.wb_stb            = stb;
    assign bus.wb_we             = 1'b0;
    assign bus.wb_sel            = 2'b11;
    assign bus.wb_adr            = adr;
    assign bus.mb_req_data       = data;
    assign bus.mb_req_data_valid = valid;
    assign bus.o_bus_err         = berr;
endmodule

// File: tb/tb_mb_wb_fetch_bridge.sv
// Directed plus randomized transactions against a per-transaction expectation model.
module tb_mb_wb_fetch_bridge;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    mb_wb_fetch_bridge_if #(.RW(16), .ADDR_W(24)) bus ();

    mb_wb_fetch_bridge #(.RW(16), .ADDR_W(24), .TIMEOUT_CYCLES(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full request: slave stalls 'stalls' cycles, then acks/errs 'dly' cycles after accept.
    task automatic run_txn(input logic [15:0] a, input logic [7:0] hi, input logic nx,
                           input int stalls, input int dly, input logic e, input logic both,
                           input logic [15:0] d, input logic stray);
        logic [23:0] exp_adr;
        logic [15:0] exp_dat;
        int stbcnt = 0;
        int w = 0;
        bit acc = 0;
        bit fired = 0;
        bit got = 0;
        exp_adr = {hi, a};
        exp_dat = e ? 16'h0000 : d;
        bus.mb_req_active = 1'b1;
        bus.mb_req_addr   = a;
        bus.i_addr_hi     = hi;
        bus.mb_req_next   = nx;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (c == 0) chk("issue_stb", 32'(bus.wb_stb), 32'd1);
            chk("cyc_hold", 32'(bus.wb_cyc), 32'd1);
            if (fired) begin
                chk("valid", 32'(bus.mb_req_data_valid), 32'd1);
                chk("data", 32'(bus.mb_req_data), 32'(exp_dat));
                chk("bus_err", 32'(bus.o_bus_err), 32'(e));
                got = 1;
                bus.wb_ack = 1'b0;
                bus.wb_err = 1'b0;
                bus.mb_req_active = 1'b0;
                bus.wb_i_dat = 16'($urandom);
                if (stray) begin
                    bus.wb_ack = 1'b1;
                    bus.wb_err = 1'($urandom_range(0, 1));
                end
            end else begin
                chk("no_early_valid", 32'(bus.mb_req_data_valid), 32'd0);
                if (bus.wb_stb) begin
                    stbcnt++;
                    chk("adr", 32'(bus.wb_adr), 32'(exp_adr));
                    if (!acc) begin
                        if (stbcnt <= stalls) bus.wb_stall = 1'b1;
                        else begin
                            bus.wb_stall = 1'b0;
                            acc = 1;
                            w = dly;
                        end
                    end
                end else begin
                    bus.wb_stall = 1'($urandom_range(0, 1));
                end
                bus.wb_i_dat = 16'($urandom);
                if (acc) begin
                    if (w == 0) begin
                        bus.wb_ack   = !e || both;
                        bus.wb_err   = e;
                        bus.wb_i_dat = d;
                        fired = 1;
                    end else w--;
                end
            end
        end
        chk("resp_seen", 32'(got), 32'd1);
        chk("stb_count", 32'(stbcnt), 32'(stalls + 1));
        @(negedge clk);
        bus.wb_ack   = 1'b0;
        bus.wb_err   = 1'b0;
        bus.wb_stall = 1'b0;
        chk("valid_one_shot", 32'(bus.mb_req_data_valid), 32'd0);
        chk("stb_idle", 32'(bus.wb_stb), 32'd0);
        chk("lock_cyc", 32'(bus.wb_cyc), 32'(nx));
    endtask

    initial begin
        rst = 1'b1;
        bus.mb_req_addr   = '0;
        bus.mb_req_active = 1'b0;
        bus.mb_req_next   = 1'b0;
        bus.i_addr_hi     = '0;
        bus.wb_i_dat      = '0;
        bus.wb_ack        = 1'b0;
        bus.wb_err        = 1'b0;
        bus.wb_stall      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(bus.wb_cyc), 32'd0);
        chk("rst_stb", 32'(bus.wb_stb), 32'd0);
        chk("rst_valid", 32'(bus.mb_req_data_valid), 32'd0);
        chk("rst_err", 32'(bus.o_bus_err), 32'd0);
        chk("rst_data", 32'(bus.mb_req_data), 32'd0);
        chk("rst_adr", 32'(bus.wb_adr), 32'd0);
        chk("we_tied", 32'(bus.wb_we), 32'd0);
        chk("sel_tied", 32'(bus.wb_sel), 32'd3);
        rst = 1'b0;
        @(negedge clk);

        // single read, ack two cycles after stb
        run_txn(16'h1234, 8'h05, 1'b0, 0, 2, 1'b0, 1'b0, 16'hBEEF, 1'b0);
        // locked pair
        run_txn(16'h0010, 8'h00, 1'b1, 0, 1, 1'b0, 1'b0, 16'hAAAA, 1'b0);
        run_txn(16'h0011, 8'h00, 1'b0, 0, 1, 1'b0, 1'b0, 16'h5555, 1'b0);
        // stall three cycles
        run_txn(16'h0420, 8'h3C, 1'b0, 3, 1, 1'b0, 1'b0, 16'h1357, 1'b0);
        // error in WAIT, then stray ack in RESP
        run_txn(16'h0BAD, 8'h7F, 1'b0, 0, 1, 1'b1, 1'b0, 16'hDEAD, 1'b1);
        // ack and err together: err wins
        run_txn(16'hFFFF, 8'hFF, 1'b0, 1, 0, 1'b1, 1'b1, 16'hC0DE, 1'b0);
        // ack in the same cycle stb is accepted
        run_txn(16'h0000, 8'h00, 1'b0, 0, 0, 1'b0, 1'b0, 16'h8001, 1'b0);

        // reset while waiting for ack
        bus.mb_req_active = 1'b1;
        bus.mb_req_addr   = 16'h2222;
        bus.i_addr_hi     = 8'h11;
        bus.mb_req_next   = 1'b1;
        @(negedge clk);
        chk("rw_stb", 32'(bus.wb_stb), 32'd1);
        @(negedge clk);
        chk("rw_wait_stb", 32'(bus.wb_stb), 32'd0);
        chk("rw_wait_cyc", 32'(bus.wb_cyc), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rw_cyc", 32'(bus.wb_cyc), 32'd0);
        chk("rw_stbr", 32'(bus.wb_stb), 32'd0);
        chk("rw_valid", 32'(bus.mb_req_data_valid), 32'd0);
        rst = 1'b0;
        bus.mb_req_active = 1'b0;
        bus.wb_ack   = 1'b1;
        bus.wb_i_dat = 16'h9999;
        @(negedge clk);
        bus.wb_ack = 1'b0;
        chk("rw_late_ack", 32'(bus.mb_req_data_valid), 32'd0);
        @(negedge clk);
        chk("rw_late_ack2", 32'(bus.mb_req_data_valid), 32'd0);
        chk("rw_idle_cyc", 32'(bus.wb_cyc), 32'd0);

`ifdef MB_WB_TIMEOUT_EN
        begin
            bit seen = 0;
            bus.mb_req_active = 1'b1;
            bus.mb_req_addr   = 16'h7777;
            bus.i_addr_hi     = 8'h01;
            bus.mb_req_next   = 1'b1;
            for (int c = 0; c < 16 && !seen; c++) begin
                @(negedge clk);
                if (bus.mb_req_data_valid) begin
                    seen = 1;
                    chk("to_data", 32'(bus.mb_req_data), 32'hFFFF);
                    chk("to_err", 32'(bus.o_bus_err), 32'd1);
                    chk("to_cyc", 32'(bus.wb_cyc), 32'd0);
                    bus.mb_req_active = 1'b0;
                end
            end
            chk("to_seen", 32'(seen), 32'd1);
            @(negedge clk);
            chk("to_idle_cyc", 32'(bus.wb_cyc), 32'd0);
            run_txn(16'h0001, 8'h02, 1'b0, 0, 1, 1'b0, 1'b0, 16'h4242, 1'b0);
        end
`endif

        // randomized traffic, locked pairs and idle gaps mixed
        for (int i = 0; i < 30; i++) begin
            logic nx;
            nx = 1'($urandom_range(0, 1));
            run_txn(16'($urandom), 8'($urandom), nx, $urandom_range(0, 3), $urandom_range(0, 4),
                    1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
                    1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("idle_gap_cyc", 32'(bus.wb_cyc), 32'd0);
            end
        end
        @(negedge clk);
        chk("final_cyc", 32'(bus.wb_cyc), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
